servant_wb_rr_arbiter: RTL and testbench

Parametrised N-master to one-slave Wishbone arbiter for the servant SoC. It generalises the fixed two-port (ibus/dbus) arbitration in front of the shared RAM to any number of masters (CPU ibus, CPU dbus, DMA, debug) with fair round-robin grant. It sits between the masters and servant_ram and holds each grant until the slave acks. An optional watchdog terminates stalled transfers.

---
 rtl/servant_pkg.sv | 23 ++
 rtl/servant_rr_pick.sv | 32 +++
 rtl/servant_wb_rr_arbiter.sv | 108 ++++++++++
 tb/tb_servant_wb_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_pkg.sv
// Shared definitions for the servant Wishbone arbiter: state encoding, bus data width
// and a one-hot to index helper.
package servant_pkg;

  localparam int SERVANT_WB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector of up to eight masters.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// Round-robin pick: rotate the request vector so ptr sits at bit 0, take the lowest
// requester, then rotate the one-hot result back into master numbering.
module servant_rr_pick #(
  parameter  int N  = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rot;
  logic [N-1:0] pick;
  logic         found;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rot   = '0;
    pick  = '0;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) rot[i] = req[(i + int'(ptr)) % N];
    for (int i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) grant[(i + int'(ptr)) % N] = pick[i];
  end

endmodule

// File: rtl/servant_wb_rr_arbiter.sv
// N-master to one-slave Wishbone arbiter with round-robin grant held until slave ack.
// Optional stalled-transfer watchdog enabled by defining SERVANT_ARB_TIMEOUT_EN.
module servant_wb_rr_arbiter
  import servant_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_MASTERS*AW-1:0]          i_wb_mst_adr,
  input  logic [NUM_MASTERS*SERVANT_WB_DW-1:0] i_wb_mst_dat,
  input  logic [NUM_MASTERS*4-1:0]           i_wb_mst_sel,
  input  logic [NUM_MASTERS-1:0]             i_wb_mst_we,
  input  logic [NUM_MASTERS-1:0]             i_wb_mst_cyc,
  output logic [SERVANT_WB_DW-1:0]           o_wb_mst_rdt,
  output logic [NUM_MASTERS-1:0]             o_wb_mst_ack,
  output logic [NUM_MASTERS-1:0]             o_wb_mst_err,
  output logic [AW-1:0]                      o_wb_slv_adr,
  output logic [SERVANT_WB_DW-1:0]           o_wb_slv_dat,
  output logic [3:0]                         o_wb_slv_sel,
  output logic                               o_wb_slv_we,
  output logic                               o_wb_slv_cyc,
  input  logic [SERVANT_WB_DW-1:0]           i_wb_slv_rdt,
  input  logic                               i_wb_slv_ack,
  output logic [NUM_MASTERS-1:0]             o_grant
);

  localparam int PW = $clog2(NUM_MASTERS);

  arb_state_e             state;
  logic [PW-1:0]          ptr;
  logic [PW-1:0]          gidx;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] pick;
  logic                   busy;
  logic                   cyc_g;
  logic                   timeout_hit;
  logic                   finish;

  servant_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (i_wb_mst_cyc),
    .ptr   (ptr),
    .grant (pick)
  );

  assign busy  = (state == ST_BUSY);
  assign cyc_g = i_wb_mst_cyc[gidx];

`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  // Fires in the TIMEOUT-th BUSY cycle; a same-cycle ack takes precedence.
  assign timeout_hit  = busy && (wd_cnt == TW'(TIMEOUT - 1)) && !i_wb_slv_ack;
  assign o_wb_mst_err = timeout_hit ? grant : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst || !busy) wd_cnt <= '0;
    else if (!i_wb_slv_ack) wd_cnt <= wd_cnt + TW'(1);
  end
`else
  assign timeout_hit  = 1'b0;
  assign o_wb_mst_err = '0;
`endif

  assign finish       = busy && (i_wb_slv_ack || !cyc_g || timeout_hit);
  assign o_wb_mst_rdt = i_wb_slv_rdt;
  assign o_wb_mst_ack = (busy && i_wb_slv_ack) ? grant : '0;
  assign o_wb_slv_cyc = busy && cyc_g && !timeout_hit;
  assign o_wb_slv_adr = busy ? i_wb_mst_adr[gidx*AW +: AW] : '0;
  assign o_wb_slv_dat = busy ? i_wb_mst_dat[gidx*SERVANT_WB_DW +: SERVANT_WB_DW] : '0;
  assign o_wb_slv_sel = busy ? i_wb_mst_sel[gidx*4 +: 4] : '0;
  assign o_wb_slv_we  = busy && i_wb_mst_we[gidx];
  assign o_grant      = grant;

  // DONE is a dead cycle so a just-acked master's stale cyc cannot win again.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gidx  <= '0;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_wb_mst_cyc) begin
            grant <= pick;
            gidx  <= PW'(onehot_idx(8'(pick)));
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (finish) begin
            grant <= '0;
            ptr   <= (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_wb_rr_arbiter.sv
// Scoreboard bench for servant_wb_rr_arbiter: a transaction-level round-robin model
// predicts grant starts, acks and errors; a negedge monitor pops and compares.
module tb_servant_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TO = 8;
`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N*AW-1:0] mst_adr;
  logic [N*32-1:0] mst_dat;
  logic [N*4-1:0]  mst_sel;
  logic [N-1:0]    mst_we;
  logic [N-1:0]    mst_cyc;
  logic [31:0]     mst_rdt;
  logic [N-1:0]    mst_ack;
  logic [N-1:0]    mst_err;
  logic [AW-1:0]   slv_adr;
  logic [31:0]     slv_dat;
  logic [3:0]      slv_sel;
  logic            slv_we;
  logic            slv_cyc;
  logic [31:0]     slv_rdt;
  logic            slv_ack;
  logic [N-1:0]    grant;

  servant_wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wb_mst_adr (mst_adr),
    .i_wb_mst_dat (mst_dat),
    .i_wb_mst_sel (mst_sel),
    .i_wb_mst_we  (mst_we),
    .i_wb_mst_cyc (mst_cyc),
    .o_wb_mst_rdt (mst_rdt),
    .o_wb_mst_ack (mst_ack),
    .o_wb_mst_err (mst_err),
    .o_wb_slv_adr (slv_adr),
    .o_wb_slv_dat (slv_dat),
    .o_wb_slv_sel (slv_sel),
    .o_wb_slv_we  (slv_we),
    .o_wb_slv_cyc (slv_cyc),
    .i_wb_slv_rdt (slv_rdt),
    .i_wb_slv_ack (slv_ack),
    .o_grant      (grant)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [N-1:0]  g;
    logic [AW-1:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    int            cyc;
  } start_t;

  typedef struct {
    logic [N-1:0] g;
    logic [31:0]  rdt;
    int           cyc;
  } resp_t;

  start_t start_q[$];
  resp_t  ack_q[$];
  resp_t  err_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Master request state and the transaction-level arbiter model.
  logic [AW-1:0] f_adr[N];
  logic [31:0]   f_dat[N];
  logic [3:0]    f_sel[N];
  logic          f_we[N];
  logic [N-1:0]  pend;
  int mptr, cur, b, lat, cool, release_m, fix_lat;
  bit aborting, gen_en, cont;

  task automatic new_req(input int k);
    pend[k]  = 1'b1;
    f_adr[k] = $urandom;
    f_dat[k] = $urandom;
    f_sel[k] = 4'($urandom);
    f_we[k]  = 1'($urandom);
  endtask

  task automatic drive_masters();
    mst_cyc = pend;
    for (int k = 0; k < N; k++) begin
      mst_adr[k*AW +: AW] = f_adr[k];
      mst_dat[k*32 +: 32] = f_dat[k];
      mst_sel[k*4 +: 4]   = f_sel[k];
      mst_we[k]           = f_we[k];
    end
  endtask

  task automatic step();
    bit ended;
    int w;
    int r;
    @(posedge clk); #1;
    slv_ack = 1'b0;
    slv_rdt = $urandom;
    if (release_m >= 0) begin
      pend[release_m] = 1'b0;
      if (cont || (gen_en && $urandom_range(0, 1) == 0)) new_req(release_m);
      release_m = -1;
    end
    if (gen_en)
      for (int k = 0; k < N; k++) if (!pend[k] && $urandom_range(0, 5) == 0) new_req(k);
    ended = 1'b0;
    if (cur >= 0) begin
      b++;
      if (b == lat + 1 && !aborting) begin
        slv_ack = 1'b1;
        ack_q.push_back(resp_t'{N'(1) << cur, slv_rdt, cyc_n});
        ended = 1'b1;
        release_m = cur;
      end else if (b == lat + 1 && aborting) begin
        pend[cur] = 1'b0;
        ended = 1'b1;
      end else if (TO_EN && b == TO) begin
        err_q.push_back(resp_t'{N'(1) << cur, 32'h0, cyc_n});
        ended = 1'b1;
        release_m = cur;
      end
      if (ended) begin
        mptr = (cur + 1) % N;
        cur  = -1;
        cool = 1;
      end
    end else if (cool > 0) begin
      cool--;
      if (gen_en && $urandom_range(0, 5) == 0) slv_ack = 1'b1;
    end else if (pend != '0) begin
      w = -1;
      for (int i = 0; i < N; i++) if (w < 0 && pend[(mptr + i) % N]) w = (mptr + i) % N;
      cur = w;
      b = 0;
      aborting = 1'b0;
      if (fix_lat > 0) lat = fix_lat;
      else begin
        r = $urandom_range(0, 11);
        if (r == 0) begin aborting = 1'b1; lat = $urandom_range(1, 3); end
        else if (r == 1) lat = TO - 1;
        else if (r == 2) lat = 20;
        else lat = $urandom_range(1, 3);
      end
      start_q.push_back(start_t'{N'(1) << w, f_adr[w], f_dat[w], f_sel[w], f_we[w], cyc_n + 1});
    end else if (gen_en && $urandom_range(0, 5) == 0) begin
      slv_ack = 1'b1;
    end
    drive_masters();
  endtask

  function automatic bit model_idle();
    return cur < 0 && cool == 0 && pend == '0 && release_m < 0;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a start, an ack or an error.
  logic   prev_cyc = 1'b0;
  start_t s_exp;
  resp_t  r_exp;

  always @(negedge clk) begin
    if (rst) begin
      prev_cyc <= 1'b0;
    end else begin
      if (slv_cyc && !prev_cyc) begin
        check("start_expected", start_q.size() != 0, 1);
        if (start_q.size() != 0) begin
          s_exp = start_q.pop_front();
          check("start_grant", grant, s_exp.g);
          check("start_cycle", cyc_n, s_exp.cyc);
          check("slv_adr", slv_adr, s_exp.adr);
          check("slv_dat", slv_dat, s_exp.dat);
          check("slv_sel_we", {slv_sel, slv_we}, {s_exp.sel, s_exp.we});
        end
      end
      if (mst_ack != '0) begin
        check("ack_expected", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) begin
          r_exp = ack_q.pop_front();
          check("ack_vector", mst_ack, r_exp.g);
          check("ack_cycle", cyc_n, r_exp.cyc);
          check("ack_rdt", mst_rdt, r_exp.rdt);
        end
      end
      if (mst_err != '0) begin
        check("err_expected", err_q.size() != 0, 1);
        check("err_slv_cyc_low", slv_cyc, 0);
        if (err_q.size() != 0) begin
          r_exp = err_q.pop_front();
          check("err_vector", mst_err, r_exp.g);
          check("err_cycle", cyc_n, r_exp.cyc);
        end
      end
      prev_cyc <= slv_cyc;
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    slv_ack = 1'b0;
    slv_rdt = '0;
    pend = '0;
    for (int k = 0; k < N; k++) begin
      f_adr[k] = '0; f_dat[k] = '0; f_sel[k] = '0; f_we[k] = 1'b0;
    end
    drive_masters();
    mptr = 0; cur = -1; b = 0; lat = 1; cool = 0; release_m = -1; fix_lat = 0;
    aborting = 1'b0; gen_en = 1'b0; cont = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_slv_cyc", slv_cyc, 0);
    check("reset_ack_err", {mst_ack, mst_err}, 0);
    check("reset_slv_adr", slv_adr, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read of 0x100 by master 0, slave acks one cycle after cyc.
    fix_lat = 1;
    new_req(0);
    f_adr[0] = 32'h100;
    f_we[0]  = 1'b0;
    repeat (5) step();

    // Master 1 moves the pointer to 2, then master 2 is reset mid-transfer.
    new_req(1);
    repeat (5) step();
    fix_lat = 20;
    new_req(2);
    repeat (3) step();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pend = '0;
    drive_masters();
    mptr = 0; cur = -1; cool = 0; release_m = -1;
    @(negedge clk);
    check("midrst_grant", grant, 0);
    check("midrst_slv_cyc", slv_cyc, 0);
    @(posedge clk); #1 slv_ack = 1'b1;
    @(posedge clk); #1 slv_ack = 1'b0;

    // All masters request continuously; master 2 carries a known write.
    fix_lat = 1;
    cont = 1'b1;
    for (int k = 0; k < N; k++) new_req(k);
    f_adr[2] = 32'h2004;
    f_dat[2] = 32'hDEADBEEF;
    f_sel[2] = 4'b0011;
    f_we[2]  = 1'b1;
    repeat (20) step();
    cont = 1'b0;
    fix_lat = 0;

    // Randomized traffic, then drain.
    gen_en = 1'b1;
    repeat (3000) step();
    gen_en = 1'b0;
    guard = 0;
    while (!model_idle() && guard < 400) begin
      step();
      guard++;
    end
    check("drain_model_idle", model_idle(), 1);
    repeat (4) step();

    check("start_q_empty", start_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    check("err_q_empty", err_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
